// File: rtl/regfile_pkg.sv
// Shared constants for the regfile_sb register file: stack-pointer op encodings,
// x86 register indices and default geometry.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_NREGS  = 8;

  localparam logic [1:0] SP_IDLE = 2'b00;
  localparam logic [1:0] SP_LOAD = 2'b01;
  localparam logic [1:0] SP_ADD  = 2'b10;

  localparam int EAX = 0;
  localparam int ECX = 1;
  localparam int EDX = 2;
  localparam int EBX = 3;
  localparam int ESP = 4;
  localparam int EBP = 5;
  localparam int ESI = 6;
  localparam int EDI = 7;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits: set by alloc, cleared by writeback or stack-pointer update.
// Updates land at the rising edge; a same-cycle set beats a clear.
module regfile_sb_scoreboard #(
  parameter int NREGS  = regfile_pkg::DEFAULT_NREGS,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int SP_IDX = regfile_pkg::ESP
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_a,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_a,
  input  logic              clr_sp,
  output logic [NREGS-1:0]  busy_vec
);

  localparam logic [ADDR_W-1:0] SP_A = SP_IDX[ADDR_W-1:0];

  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_vec;
    if (clr_en) busy_nxt[clr_a] = 1'b0;
    if (clr_sp) busy_nxt[SP_A]  = 1'b0;
    // Reservation is applied last so a new in-flight producer is never lost.
    if (set_en) busy_nxt[set_a] = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, stack-pointer load/add port
// and busy scoreboard; writes at the clk edge, no backpressure. REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter int                NREGS     = DEFAULT_NREGS,
  parameter int                ADDR_W    = $clog2(NREGS),
  parameter logic [DATA_W-1:0] RESET_VAL = 1,
  parameter int                SP_IDX    = ESP
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [ADDR_W-1:0]       ra1,
  input  logic [ADDR_W-1:0]       ra2,
  output logic [DATA_W-1:0]       rd1,
  output logic [DATA_W-1:0]       rd2,
  output logic                    rdy1,
  output logic                    rdy2,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic [1:0]              sp_op,
  input  logic [DATA_W-1:0]       spd,
  output logic [DATA_W-1:0]       resp,
  input  logic                    alloc_en,
  input  logic [ADDR_W-1:0]       alloc_a,
  output logic [NREGS-1:0]        busy_vec,
  output logic [NREGS*DATA_W-1:0] rf_flat
);

  localparam logic [ADDR_W-1:0] SP_A = SP_IDX[ADDR_W-1:0];

  logic [DATA_W-1:0] rf [NREGS];
  logic              sp_act;
  logic [DATA_W-1:0] sp_nxt;
  logic              gen_we;

  // Reserved encoding 11 behaves as idle.
  assign sp_act = (sp_op == SP_LOAD) || (sp_op == SP_ADD);
  assign sp_nxt = (sp_op == SP_LOAD) ? spd : rf[SP_A] + spd;
  assign gen_we = we && !(sp_act && (wa == SP_A));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= RESET_VAL;
    end else begin
      if (gen_we) rf[wa]   <= wd;
      if (sp_act) rf[SP_A] <= sp_nxt;
    end
  end

  regfile_sb_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W),
    .SP_IDX (SP_IDX)
  ) u_sb (
    .clk      (clk),
    .n_rst    (n_rst),
    .set_en   (alloc_en),
    .set_a    (alloc_a),
    .clr_en   (we),
    .clr_a    (wa),
    .clr_sp   (sp_act),
    .busy_vec (busy_vec)
  );

  always_comb begin
    rd1  = rf[ra1];
    rdy1 = !busy_vec[ra1];
    rd2  = rf[ra2];
    rdy2 = !busy_vec[ra2];
`ifdef REGFILE_BYPASS_EN
    if (sp_act && (ra1 == SP_A)) begin
      rd1  = sp_nxt;
      rdy1 = 1'b1;
    end else if (we && (wa == ra1)) begin
      rd1  = wd;
      rdy1 = 1'b1;
    end
    if (sp_act && (ra2 == SP_A)) begin
      rd2  = sp_nxt;
      rdy2 = 1'b1;
    end else if (we && (wa == ra2)) begin
      rd2  = wd;
      rdy2 = 1'b1;
    end
`endif
  end

  assign resp = rf[SP_A];

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign rf_flat[g*DATA_W +: DATA_W] = rf[g];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default 32x8 geometry).
module tb_regfile_sb;
  import regfile_pkg::*;

  logic         clk;
  logic         n_rst;
  logic [2:0]   ra1, ra2, wa, alloc_a;
  logic [31:0]  rd1, rd2, wd, spd, resp;
  logic         rdy1, rdy2, we, alloc_en;
  logic [1:0]   sp_op;
  logic [7:0]   busy_vec;
  logic [255:0] rf_flat;

  int tests = 0;
  int fails = 0;

  localparam logic [255:0] ALL_ONES_RF = {8{32'h0000_0001}};

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .rdy1     (rdy1),
    .rdy2     (rdy2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .sp_op    (sp_op),
    .spd      (spd),
    .resp     (resp),
    .alloc_en (alloc_en),
    .alloc_a  (alloc_a),
    .busy_vec (busy_vec),
    .rf_flat  (rf_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0;
    sp_op = SP_IDLE; spd = '0;
    alloc_en = 1'b0; alloc_a = '0;
  endtask

  initial begin
    n_rst = 1'b0;
    ra1 = '0; ra2 = '0;
    idle_inputs();
    #12;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(7 - i);
      #1;
      check($sformatf("rst_rd1[%0d]", i), rd1, 32'h1);
      check($sformatf("rst_rd2[%0d]", i), rd2, 32'h1);
      check($sformatf("rst_rdy1[%0d]", i), rdy1, 1'b1);
    end
    check("rst_busy", busy_vec, 8'h00);
    check("rst_resp", resp, 32'h1);
    check("rst_flat", rf_flat, ALL_ONES_RF);
    n_rst = 1'b1;
    tick();

    // General write and read-after-write timing
    we = 1'b1; wa = EBX; wd = 32'hDEADBEEF; ra1 = EBX;
    #1;
    check("wr_same_cycle_rd1", rd1, BYP ? 32'hDEADBEEF : 32'h1);
    tick();
    idle_inputs();
    #1;
    check("wr_next_cycle_rd1", rd1, 32'hDEADBEEF);

    // Stack-pointer load/add sequence
    sp_op = SP_LOAD; spd = 32'h0000_1000; ra2 = ESP;
    #1;
    check("sp_load_same_cycle_rd2", rd2, BYP ? 32'h0000_1000 : 32'h1);
    tick();
    check("sp_load", resp, 32'h0000_1000);
    sp_op = SP_ADD; spd = 32'hFFFF_FFFC;
    tick();
    check("sp_add_neg4", resp, 32'h0000_0FFC);
    spd = 32'h4;
    tick();
    tick();
    check("sp_add_4x2", resp, 32'h0000_1004);
    sp_op = SP_LOAD; spd = 32'hFFFF_FFFF;
    tick();
    sp_op = SP_ADD; spd = 32'h1;
    tick();
    check("sp_wrap", resp, 32'h0);

    // Write/stack-pointer conflict: stack-pointer port wins
    sp_op = SP_LOAD; spd = 32'h5678; we = 1'b1; wa = ESP; wd = 32'h1234;
    tick();
    idle_inputs();
    ra1 = ESP;
    #1;
    check("conflict_resp", resp, 32'h5678);
    check("conflict_rd1", rd1, 32'h5678);

    // Reserved op acts as idle
    sp_op = 2'b11; spd = 32'h5;
    tick();
    idle_inputs();
    check("sp_reserved", resp, 32'h5678);

    // Scoreboard: alloc, alloc+write, write
    alloc_en = 1'b1; alloc_a = EDX; ra1 = EDX;
    #1;
    check("alloc_pre_edge_busy", busy_vec, 8'h00);
    tick();
    idle_inputs();
    #1;
    check("alloc_busy", busy_vec, 8'h04);
    check("alloc_rdy1", rdy1, 1'b0);
    alloc_en = 1'b1; alloc_a = EDX; we = 1'b1; wa = EDX; wd = 32'hCAFE_0002;
    #1;
    check("alloc_wr_same_cycle_rdy1", rdy1, BYP);
    tick();
    idle_inputs();
    #1;
    check("alloc_wins_busy", busy_vec, 8'h04);
    check("alloc_wins_data", rd1, 32'hCAFE_0002);
    we = 1'b1; wa = EDX; wd = 32'h22;
    tick();
    idle_inputs();
    #1;
    check("clear_busy", busy_vec, 8'h00);
    check("clear_rdy1", rdy1, 1'b1);
    check("clear_rd1", rd1, 32'h22);

    // Double alloc stays busy; stack-pointer op clears ESP busy
    alloc_en = 1'b1; alloc_a = EBP;
    tick();
    tick();
    alloc_a = ESP;
    tick();
    idle_inputs();
    check("double_alloc_busy", busy_vec, 8'h30);
    sp_op = SP_ADD; spd = 32'h2;
    tick();
    idle_inputs();
    check("sp_clears_busy", busy_vec, 8'h20);
    check("sp_add_after_alloc", resp, 32'h567A);
    we = 1'b1; wa = EBP; wd = 32'h55;
    tick();
    idle_inputs();
    check("ebp_cleared", busy_vec, 8'h00);

    // Asynchronous reset mid-cycle discards pending activity
    we = 1'b1; wa = ECX; wd = 32'hAAAA_AAAA;
    alloc_en = 1'b1; alloc_a = ECX;
    sp_op = SP_LOAD; spd = 32'h9;
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_busy_immediate", busy_vec, 8'h00);
    check("arst_flat_immediate", rf_flat, ALL_ONES_RF);
    check("arst_resp_immediate", resp, 32'h1);
    tick();
    check("arst_hold_flat", rf_flat, ALL_ONES_RF);
    check("arst_hold_busy", busy_vec, 8'h00);
    idle_inputs();
    n_rst = 1'b1;
    tick();
    check("post_arst_flat", rf_flat, ALL_ONES_RF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
